// File: rtl/adc_peak_window_monitor_pkg.sv
// Shared definitions for the ADC peak window monitor.
// The package holds the FSM state encoding that the top level uses. The same
// encoding is exported on the debug port so that checkers can bind to it.
package adc_peak_window_monitor_pkg;

  // IDLE: the monitor is disabled and the accumulators are held clear.
  // RUN:  the monitor accumulates samples and closes a window each time the
  //       remaining-sample count reaches one.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/adc_peak_window_ch.sv
// One channel of the peak window monitor.
// Accumulates the running peak, a saturating full-scale hit count and a sticky
// over-threshold flag. At a window end the final values, which include the
// sample present on that edge, are copied to the latched outputs. The
// accumulators restart on the same edge.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   sample_i     this cycle's channel maximum (unsigned)
//   thresh_i     live over-threshold level
//   acc_en_i     the sample on this edge belongs to a window
//   win_end_i    this edge closes the window (only meaningful with acc_en_i)
//   peak_o       latched window peak
//   sat_cnt_o    latched full-scale sample count
//   over_o       latched over-threshold flag
module adc_peak_window_ch #(
  parameter int W  = 8,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  sample_i,
  input  logic [W-1:0]  thresh_i,
  input  logic          acc_en_i,
  input  logic          win_end_i,
  output logic [W-1:0]  peak_o,
  output logic [SW-1:0] sat_cnt_o,
  output logic          over_o
);

  logic [W-1:0]  acc_peak_q, fin_peak;
  logic [SW-1:0] acc_sat_q, fin_sat;
  logic          acc_over_q, fin_over;
  logic [W-1:0]  peak_q;
  logic [SW-1:0] sat_q;
  logic          over_q;

  // Window totals that include the current edge's sample.
  always_comb begin
    fin_peak = (sample_i > acc_peak_q) ? sample_i : acc_peak_q;
    fin_sat  = acc_sat_q;
    // The count holds at all-ones instead of wrapping back to zero.
    if ((sample_i == '1) && (acc_sat_q != '1)) begin
      fin_sat = acc_sat_q + SW'(1);
    end
    fin_over = acc_over_q | (sample_i > thresh_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_peak_q <= '0;
      acc_sat_q  <= '0;
      acc_over_q <= 1'b0;
      peak_q     <= '0;
      sat_q      <= '0;
      over_q     <= 1'b0;
    end else begin
      // A dropped enable discards the partial window. A window end starts the
      // next window from scratch.
      if (!acc_en_i || win_end_i) begin
        acc_peak_q <= '0;
        acc_sat_q  <= '0;
        acc_over_q <= 1'b0;
      end else begin
        acc_peak_q <= fin_peak;
        acc_sat_q  <= fin_sat;
        acc_over_q <= fin_over;
      end
      if (acc_en_i && win_end_i) begin
        peak_q <= fin_peak;
        sat_q  <= fin_sat;
        over_q <= fin_over;
      end
    end
  end

  assign peak_o    = peak_q;
  assign sat_cnt_o = sat_q;
  assign over_o    = over_q;

endmodule

// File: rtl/adc_peak_window_monitor.sv
// ADC peak window monitor, top level.
// This block reduces the per-cycle channel maxima over a programmable window.
// At each window end it reports the peak, the full-scale hit count and the
// over-threshold flag for every channel. It then pulses peak_valid_o.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   adc_max_i      per-cycle maxima, channel c at [c*W +: W]
//   en_i           monitor enable (level)
//   win_len_i      window length in cycles (0 behaves as 1)
//   thresh_i       over-threshold level shared by all channels
//   peak_o         latched per-channel window peak
//   sat_cnt_o      latched per-channel full-scale count
//   over_o         latched per-channel over-threshold flag
//   peak_valid_o   one-cycle strobe after the latched outputs update
//   busy_o         high while in RUN
//   dbg_state_o    current FSM state
// Handshake: there is no back-pressure. peak_valid_o is a pure strobe, and the
// latched outputs are stable from the strobe until the next window end.
module adc_peak_window_monitor
  import adc_peak_window_monitor_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int NUM_CH         = 2,
  parameter int WIN_WIDTH      = 16,
  parameter int SAT_CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADC_DATA_WIDTH*NUM_CH-1:0]  adc_max_i,
  input  logic                              en_i,
  input  logic [WIN_WIDTH-1:0]              win_len_i,
  input  logic [ADC_DATA_WIDTH-1:0]         thresh_i,
  output logic [ADC_DATA_WIDTH*NUM_CH-1:0]  peak_o,
  output logic [SAT_CNT_WIDTH*NUM_CH-1:0]   sat_cnt_o,
  output logic [NUM_CH-1:0]                 over_o,
  output logic                              peak_valid_o,
  output logic                              busy_o,
  output state_e                            dbg_state_o
);

  state_e               state_q;
  logic [WIN_WIDTH-1:0] rem_q;
  logic [WIN_WIDTH-1:0] len_eff, rem_now;
  logic                 win_end;
  logic                 busy_q, valid_q;

  // rem_now counts the samples still owed to the window, including the sample
  // on this edge. The edge that leaves IDLE takes the first sample, so in IDLE
  // the count comes straight from win_len_i.
  always_comb begin
    len_eff = (win_len_i == '0) ? WIN_WIDTH'(1) : win_len_i;
    rem_now = (state_q == ST_RUN) ? rem_q : len_eff;
    win_end = en_i && (rem_now == WIN_WIDTH'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= win_end;
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            rem_q   <= win_end ? len_eff : rem_now - WIN_WIDTH'(1);
          end else begin
            rem_q <= '0;
          end
        end
        ST_RUN: begin
          if (!en_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            rem_q   <= '0;
          end else begin
            // A new win_len_i is picked up only at a window boundary.
            rem_q <= win_end ? len_eff : rem_now - WIN_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          rem_q   <= '0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    adc_peak_window_ch #(
      .W  (ADC_DATA_WIDTH),
      .SW (SAT_CNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sample_i  (adc_max_i[c*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
      .thresh_i  (thresh_i),
      .acc_en_i  (en_i),
      .win_end_i (win_end),
      .peak_o    (peak_o[c*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
      .sat_cnt_o (sat_cnt_o[c*SAT_CNT_WIDTH +: SAT_CNT_WIDTH]),
      .over_o    (over_o[c])
    );
  end

  assign peak_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adc_peak_window_monitor.sv
// Directed bench for adc_peak_window_monitor.
// The DUT is built with two channels and a 4-bit saturation counter.
module tb_adc_peak_window_monitor;
  import adc_peak_window_monitor_pkg::*;

  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int WW  = 16;
  localparam int SW  = 4;

  logic              clk;
  logic              rst;
  logic [W*NCH-1:0]  adc_max;
  logic              en;
  logic [WW-1:0]     win_len;
  logic [W-1:0]      thresh;
  logic [W*NCH-1:0]  peak;
  logic [SW*NCH-1:0] sat_cnt;
  logic [NCH-1:0]    over;
  logic              peak_valid;
  logic              busy;
  state_e            dbg_state;

  int n_vec = 0;
  int n_err = 0;

  adc_peak_window_monitor #(
    .ADC_DATA_WIDTH (W),
    .NUM_CH         (NCH),
    .WIN_WIDTH      (WW),
    .SAT_CNT_WIDTH  (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_max_i    (adc_max),
    .en_i         (en),
    .win_len_i    (win_len),
    .thresh_i     (thresh),
    .peak_o       (peak),
    .sat_cnt_o    (sat_cnt),
    .over_o       (over),
    .peak_valid_o (peak_valid),
    .busy_o       (busy),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one sample pair with the given enable, then stop 1 ns after the edge.
  task automatic step(input logic e, input logic [W-1:0] c0, input logic [W-1:0] c1);
    en      = e;
    adc_max = {c1, c0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    adc_max = '0;
    win_len = 16'd4;
    thresh  = 8'd200;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_peak", 64'(peak), 64'd0);
    chk("rst_sat", 64'(sat_cnt), 64'd0);
    chk("rst_over", 64'(over), 64'd0);
    chk("rst_valid", 64'(peak_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step(1'b0, 8'd0, 8'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Window of 4: ch0 10,50,20,30 and ch1 all 5.
    step(1'b1, 8'd10, 8'd5);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_state", 64'(dbg_state), 64'(ST_RUN));
    chk("t1_novalid0", 64'(peak_valid), 64'd0);
    step(1'b1, 8'd50, 8'd5);
    step(1'b1, 8'd20, 8'd5);
    chk("t1_novalid2", 64'(peak_valid), 64'd0);
    win_len = 16'd3;   // takes effect at the boundary below
    thresh  = 8'd254;
    step(1'b1, 8'd30, 8'd5);
    chk("t1_valid", 64'(peak_valid), 64'd1);
    chk("t1_peak", 64'(peak), 64'h0532);
    chk("t1_sat", 64'(sat_cnt), 64'd0);
    chk("t1_over", 64'(over), 64'd0);

    // Window of 3: ch0 255,255,7 and ch1 0.
    step(1'b1, 8'd255, 8'd0);
    chk("t2_novalid", 64'(peak_valid), 64'd0);
    step(1'b1, 8'd255, 8'd0);
    step(1'b1, 8'd7, 8'd0);
    chk("t2_valid", 64'(peak_valid), 64'd1);
    chk("t2_peak", 64'(peak), 64'h00ff);
    chk("t2_sat", 64'(sat_cnt), 64'h02);
    chk("t2_over", 64'(over), 64'b01);

    // An all-zero window clears everything.
    step(1'b1, 8'd0, 8'd0);
    step(1'b1, 8'd0, 8'd0);
    win_len = 16'd0;
    step(1'b1, 8'd0, 8'd0);
    chk("t2z_valid", 64'(peak_valid), 64'd1);
    chk("t2z_peak", 64'(peak), 64'd0);
    chk("t2z_sat", 64'(sat_cnt), 64'd0);
    chk("t2z_over", 64'(over), 64'd0);

    // win_len 0 gives a strobe every cycle, and peak follows the input.
    step(1'b1, 8'd17, 8'd1);
    chk("t3_valid_a", 64'(peak_valid), 64'd1);
    chk("t3_peak_a", 64'(peak), 64'h0111);
    step(1'b1, 8'd99, 8'd2);
    chk("t3_valid_b", 64'(peak_valid), 64'd1);
    chk("t3_peak_b", 64'(peak), 64'h0263);
    win_len = 16'd8;
    step(1'b1, 8'd3, 8'd0);
    chk("t3_valid_c", 64'(peak_valid), 64'd1);
    chk("t3_peak_c", 64'(peak), 64'h0003);

    // 8-cycle window. The length changes to 2 mid-window and applies afterwards.
    step(1'b1, 8'd1, 8'd0);
    chk("t5_novalid1", 64'(peak_valid), 64'd0);
    win_len = 16'd2;
    for (int i = 2; i <= 7; i++) step(1'b1, 8'(i), 8'd0);
    chk("t5_novalid7", 64'(peak_valid), 64'd0);
    step(1'b1, 8'd8, 8'd0);
    chk("t5_valid8", 64'(peak_valid), 64'd1);
    chk("t5_peak8", 64'(peak), 64'h0008);
    step(1'b1, 8'd40, 8'd0);
    chk("t5_novalid_a", 64'(peak_valid), 64'd0);
    win_len = 16'd5;
    step(1'b1, 8'd12, 8'd0);
    chk("t5_valid2", 64'(peak_valid), 64'd1);
    chk("t5_peak2", 64'(peak), 64'h0028);

    // Drop en_i on cycle 2 of a 5-cycle window.
    step(1'b1, 8'd9, 8'd0);
    chk("t4_novalid1", 64'(peak_valid), 64'd0);
    step(1'b0, 8'd90, 8'd0);
    chk("t4_novalid2", 64'(peak_valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_state", 64'(dbg_state), 64'(ST_IDLE));
    step(1'b0, 8'd0, 8'd0);
    chk("t4_peak", 64'(peak), 64'h0028);
    chk("t4_idle_valid", 64'(peak_valid), 64'd0);

    // A 20-cycle window of full-scale samples saturates the 4-bit count at 15.
    win_len = 16'd20;
    for (int i = 1; i <= 20; i++) step(1'b1, 8'd255, 8'd1);
    chk("t6_valid", 64'(peak_valid), 64'd1);
    chk("t6_sat", 64'(sat_cnt), 64'h0f);
    chk("t6_peak", 64'(peak), 64'h01ff);
    chk("t6_over", 64'(over), 64'b01);

    // Assert reset mid-window, away from any clock edge.
    step(1'b1, 8'd255, 8'd255);
    step(1'b1, 8'd255, 8'd255);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_peak", 64'(peak), 64'd0);
    chk("t6_rst_sat", 64'(sat_cnt), 64'd0);
    chk("t6_rst_over", 64'(over), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_valid", 64'(peak_valid), 64'd0);
    en = 1'b0;
    #10;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
